// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the EXE stage and the multiply/divide sequencer.
interface muldiv_seq_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        id_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        md_stall;

    // Pipeline side: issues operations, reads HI/LO and the stall request.
    modport master (
        output start, op, a, b, cancel, id_hilo,
        input  hi, lo, busy, done, md_stall
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b, cancel, id_hilo,
        output hi, lo, busy, done, md_stall
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply or restoring divide on magnitudes over 32
// RUN cycles, followed by one FIX cycle that applies signs and writes HI/LO.
module muldiv_seq (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [31:0] a_orig_q, a_orig_d;  // raw dividend, returned in HI on divide by zero
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;        // negate product / quotient
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        busy;
    logic        launch;
    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] product;

    assign busy   = (state_q != IDLE);
    assign launch = bus.start & ~bus.cancel & ~bus.op[2];

    // Operand magnitudes and one iteration of each algorithm.
    always_comb begin
        signed_op = ~bus.op[0];
        a_mag     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
        b_mag     = (signed_op && bus.b[31]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        div_shift = acc_q[63:31];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[32];
        div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
        product   = neg_q ? -acc_q : acc_q;
    end

    // Next-state logic of the sequencer FSM.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (bus.cancel) state_d = IDLE;
                     else if (cnt_q == 6'd31) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, iterations, sign fix-up, MTHI/MTLO.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_orig_d  = a_orig_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    is_div_d  = bus.op[1];
                    acc_d     = {32'd0, (bus.op[1] ? a_mag : b_mag)};
                    opnd_d    = bus.op[1] ? b_mag : a_mag;
                    a_orig_d  = bus.a;
                    neg_d     = signed_op & (bus.a[31] ^ bus.b[31]);
                    rem_neg_d = signed_op & bus.a[31];
                    cnt_d     = 6'd0;
                end else if (bus.start && !bus.cancel && bus.op[2:1] == 2'b10) begin
                    if (bus.op[0]) lo_d = bus.a;
                    else           hi_d = bus.a;
                end
            end
            RUN: begin
                if (!bus.cancel) begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            FIX: begin
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (opnd_q == 32'd0) begin
                        hi_d = a_orig_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
                        lo_d = neg_q ? -acc_q[31:0] : acc_q[31:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, accumulators included, is cleared on reset so a discarded operation leaves nothing behind.
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            a_orig_q  <= 32'd0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_orig_q  <= a_orig_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.md_stall = bus.id_hilo & (busy | (bus.start & ~bus.op[2]));
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO registers of the 5-stage pipeline CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EXE stage. It runs radix-2 shift-add or restoring-divide iterations over 33 cycles, and raises a stall request to the Control unit while an ID-stage instruction needs HI/LO or the unit. It sits beside the ALU in EXE; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- No parameters; data width is fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: EXE-stage instruction is a muldiv op; sampled on `clk`.
- `op` in 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- `a` in 32: rs operand (dividend / multiplicand / MT source).
- `b` in 32: rt operand (divisor / multiplier).
- `cancel` in 1: pipeline flush; aborts the operation in flight.
- `id_hilo` in 1: ID-stage instruction is MFHI/MFLO/MTHI/MTLO or any muldiv op.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: high when state is not IDLE.
- `done` out 1: one-cycle pulse when `hi`/`lo` are written by MULT*/DIV*.
- `md_stall` out 1: combinational; equals `id_hilo & (busy | (start & ~op[2]))`.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - `start` with op 000–011: latch |a| and |b| (magnitudes for the signed ops, raw values for the unsigned ops); latch the result signs; clear the 6-bit counter; go to RUN.
  - `start` with op 100: `hi<=a`. op 101: `lo<=a`. State stays IDLE; `busy` stays 0.
  - op 110/111: no effect.
- RUN: one iteration per cycle, counter 0..31; after iteration 31 go to FIX.
  - Multiply: 64-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, set the quotient bit on a non-negative result.
- FIX: apply signs, write `hi`/`lo`, pulse `done`, go to IDLE.
  - Signed multiply: negate the 64-bit product when the operand signs differ.
  - Signed divide: quotient negated when signs differ; remainder takes the sign of the dividend.
  - Results: MULT* gives hi = product[63:32], lo = product[31:0]. DIV* gives lo = quotient, hi = remainder.
- Divide by zero: runs the full latency; `lo=32'hFFFF_FFFF`, `hi=a` (the original dividend).
- Signed overflow (0x80000000 / -1): `lo=32'h8000_0000`, `hi=0`, which falls out of the magnitude algorithm.
- `start` while `busy`: ignored, including MTHI/MTLO. Control must prevent this through `md_stall`.
- `cancel`: from RUN or FIX, return to IDLE next edge. `hi`/`lo` are unchanged and `done` is not pulsed.
- `cancel` and `start` asserted together in IDLE: `cancel` wins and the start is dropped.
- `cancel` in IDLE alone has no effect.

## Timing
- Reset (async, `rst_n=0`): state IDLE, `hi=0`, `lo=0`, `busy=0`, `done=0`, counter 0, internal accumulators 0. Reset during RUN or FIX discards the operation.
- MULT*/DIV* sequence, with `start` sampled at edge N:
  - After edge N: state RUN, `busy=1`.
  - Edges N+1 through N+32: the 32 iterations.
  - After edge N+32: state FIX.
  - At edge N+33: `hi`/`lo` updated, `done=1` for one cycle, `busy=0`.
  - `busy` is high for exactly 33 cycles.
- A new `start` is accepted at edge N+34 at the earliest, i.e. the cycle in which `done=1`, since the state is IDLE then.
- MTHI/MTLO: the register is updated at the same edge that samples `start`; the new value is visible the following cycle.
- `md_stall` is combinational.
  - Covers the back-to-back case: with `start` high for a MULT*/DIV* and `id_hilo` high in the same cycle, `md_stall=1`.
  - Drops in the cycle in which `done=1`.
- `hi`/`lo` never change except at the FIX edge, at an MTHI/MTLO edge, or on reset.

## Test plan
- Reset, then MULT with a=7, b=0xFFFFFFFD (-3): `busy` high for 33 cycles; then `hi=FFFFFFFF`, `lo=FFFFFFEB`, and `done` pulses once.
- DIV a=0xFFFFFFF9 (-7), b=2 → `lo=FFFFFFFD`, `hi=FFFFFFFF`. DIVU a=100, b=0 → `lo=FFFFFFFF`, `hi=00000064`.
- MULTU a=b=FFFFFFFF → `hi=FFFFFFFE`, `lo=00000001`. DIV a=80000000, b=FFFFFFFF → `lo=80000000`, `hi=0`.
- MULT 3×5 with `id_hilo=1` held: `md_stall=1` from the `start` cycle through the FIX cycle, 34 cycles total; it is 0 in the `done` cycle, and `lo=15`.
- MTHI a=0x12345678 in IDLE → `hi=12345678` next cycle with `busy=0`. Then start DIV and, while busy, MTLO a=0xAAAA: `lo` equals the quotient, not 0xAAAA.
- Start MULT 6×7 and assert `cancel` at iteration 10: `busy=0` next cycle, `hi`/`lo` keep their prior values, no `done`. Repeat with `rst_n` pulsed low mid-RUN → all outputs 0 asynchronously.
